// File: rtl/alu_seq_if.sv
// Bus between the control sequencer (master) and the multi-cycle ALU (slave):
// request fields travel with start, results and status come back.
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc_data;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] arg_data;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             is_zero;
  logic             is_neg;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, op, acc_data, mem_data, arg_data, shamt,
    input  result, is_zero, is_neg, carry, busy, done
  );

  modport slave (
    input  start, op, acc_data, mem_data, arg_data, shamt,
    output result, is_zero, is_neg, carry, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: NAND / load / pass complete in one cycle, shifts and
// rotates move one bit per clock, with a one-cycle done pulse on completion.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [2:0] OP_NAD  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ARG  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] stepVal;
  logic             stepOut;
  logic             accept;
  logic             shiftReq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= OP_NAD;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
    end
  end

  // One-bit move of the working register for the latched shift/rotate op.
  always_comb begin
    stepVal = work_q;
    stepOut = 1'b0;
    case (op_q)
      OP_SHR: begin stepVal = {1'b0, work_q[WIDTH-1:1]};              stepOut = work_q[0];       end
      OP_SHL: begin stepVal = {work_q[WIDTH-2:0], 1'b0};              stepOut = work_q[WIDTH-1]; end
      OP_ASR: begin stepVal = {work_q[WIDTH-1], work_q[WIDTH-1:1]};   stepOut = work_q[0];       end
      OP_ROR: begin stepVal = {work_q[0], work_q[WIDTH-1:1]};         stepOut = work_q[0];       end
      OP_ROL: begin stepVal = {work_q[WIDTH-2:0], work_q[WIDTH-1]};   stepOut = work_q[WIDTH-1]; end
      default: begin stepVal = work_q;                                stepOut = 1'b0;            end
    endcase
  end

  assign accept   = bus.start && (state_q != SHIFT);
  assign shiftReq = (bus.op != OP_NAD) && (bus.op != OP_ARG) && (bus.op != OP_PASS);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d = bus.op;
          if (shiftReq && (bus.shamt != '0)) begin
            work_d  = bus.acc_data;
            cnt_d   = bus.shamt;
            state_d = SHIFT;
          end else begin
            // Zero-distance shifts fall through to the acc pass-through.
            carry_d = 1'b0;
            state_d = DONE;
            case (bus.op)
              OP_NAD:  result_d = ~(bus.acc_data & bus.mem_data);
              OP_ARG:  result_d = bus.arg_data;
              default: result_d = bus.acc_data;
            endcase
          end
        end
      end
      SHIFT: begin
        work_d = stepVal;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = stepVal;
          carry_d  = stepOut;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result  = result_q;
  assign bus.is_zero = (result_q == '0);
  assign bus.is_neg  = result_q[WIDTH-1];
  assign bus.carry   = carry_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);

endmodule
